seg_595_rx: RTL

SEG_595_RX -- requirements
Module: seg_595_rx

---
 rtl/seg_595_rx.sv | 135 +++++++++++++
 1 files changed

// File: rtl/seg_595_rx.sv
// Receiver for a 74HC595 serial display bus: oversamples shcp/stcp/ds on sys_clk,
// rebuilds the storage register, and keeps a per-digit copy of the last valid segment code.
module seg_595_rx #(
    parameter int FRAME_W   = 14,
    parameter int DIGIT_NUM = 6,
    parameter int IDLE_TO   = 1000
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst_n,
    input  logic                     shcp,
    input  logic                     stcp,
    input  logic                     ds,
    output logic [7:0]               seg_out,
    output logic [DIGIT_NUM-1:0]     sel_out,
    output logic [8*DIGIT_NUM-1:0]   disp_seg,
    output logic [DIGIT_NUM-1:0]     digit_upd,
    output logic                     frame_valid,
    output logic                     frame_err
);

    localparam int IDLE_W = $clog2(IDLE_TO + 1);

    function automatic logic is_onehot(input logic [DIGIT_NUM-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < DIGIT_NUM; i++) begin
            if (v[i]) n++;
        end
        return (n == 1);
    endfunction

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'd15) ? 4'd15 : v + 4'd1;
    endfunction

    logic shcp_p0, shcp_p1, shcp_p2;
    logic stcp_p0, stcp_p1, stcp_p2;
    logic ds_p0, ds_p1;

    logic [FRAME_W-1:0]   sreg;
    logic [3:0]           bit_cnt;
    logic [IDLE_W-1:0]    idle_cnt;

    logic                 shcp_rise, stcp_rise, idle_hit, frame_ok;
    logic [FRAME_W-1:0]   sreg_nxt;
    logic [3:0]           cnt_nxt;
    logic [7:0]           seg_nxt;
    logic [DIGIT_NUM-1:0] sel_nxt;

    // Stage p0/p1: two-flop synchronisers; p2: history for rise detection
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            shcp_p0 <= 1'b0;
            shcp_p1 <= 1'b0;
            shcp_p2 <= 1'b0;
            stcp_p0 <= 1'b0;
            stcp_p1 <= 1'b0;
            stcp_p2 <= 1'b0;
            ds_p0   <= 1'b0;
            ds_p1   <= 1'b0;
        end else begin
            shcp_p0 <= shcp;
            shcp_p1 <= shcp_p0;
            shcp_p2 <= shcp_p1;
            stcp_p0 <= stcp;
            stcp_p1 <= stcp_p0;
            stcp_p2 <= stcp_p1;
            ds_p0   <= ds;
            ds_p1   <= ds_p0;
        end
    end

    // A coincident latch sees the shift that happens on the same edge
    always_comb begin
        shcp_rise = shcp_p1 & ~shcp_p2;
        stcp_rise = stcp_p1 & ~stcp_p2;
        idle_hit  = (idle_cnt == IDLE_W'(IDLE_TO));
        sreg_nxt  = shcp_rise ? {sreg[FRAME_W-2:0], ds_p1} : sreg;
        cnt_nxt   = shcp_rise ? sat_inc(bit_cnt) : bit_cnt;
        seg_nxt   = sreg_nxt[FRAME_W-1 -: 8];
        sel_nxt   = sreg_nxt[DIGIT_NUM-1:0];
        frame_ok  = (cnt_nxt == 4'(FRAME_W)) && is_onehot(sel_nxt);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sreg     <= '0;
            bit_cnt  <= 4'd0;
            idle_cnt <= '0;
        end else begin
            sreg <= sreg_nxt;
            if (stcp_rise)
                bit_cnt <= 4'd0;
            else if (shcp_rise)
                bit_cnt <= cnt_nxt;
            else if (idle_hit)
                bit_cnt <= 4'd0;
            if (shcp_rise || stcp_rise)
                idle_cnt <= '0;
            else if (!idle_hit)
                idle_cnt <= idle_cnt + IDLE_W'(1);
        end
    end

    // Storage register and digit table update on the latch edge
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            seg_out     <= 8'hFF;
            sel_out     <= '0;
            disp_seg    <= {DIGIT_NUM{8'hFF}};
            digit_upd   <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            digit_upd   <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            if (stcp_rise) begin
                seg_out     <= seg_nxt;
                sel_out     <= sel_nxt;
                frame_valid <= frame_ok;
                frame_err   <= ~frame_ok;
                if (frame_ok) begin
                    for (int n = 0; n < DIGIT_NUM; n++) begin
                        if (sel_nxt[n]) begin
                            disp_seg[8*n +: 8] <= seg_nxt;
                            digit_upd[n]       <= 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule
